// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Optional tick strobe is selected by the CLKDIV_TICK_EN macro (see clkdiv_channel).
package clkdiv_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int MIN_RATIO = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Ratios below MIN_RATIO cannot form a high and a low phase, so they are raised.
   function automatic logic [31:0] clamp_ratio(input logic [31:0] v);
      return (v < 32'(MIN_RATIO)) ? 32'(MIN_RATIO) : v;
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: IDLE/RUN/DRAIN FSM, period counter, shadow and active ratio.
// CLKDIV_TICK_EN adds a registered 1-cycle strobe on each rising edge of o_clk.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_ratio,
   output logic             o_clk,
   output logic             o_tick,
   output state_e           o_state
);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_shadow;
   logic [CNT_W-1:0] r_ratio;
   logic             r_clk;

   state_e           w_state_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_shadow_next;
   logic [CNT_W-1:0] w_ratio_next;
   logic [CNT_W-1:0] w_load_val;
   logic             w_clk_next;
   logic             w_wrap;

   assign w_load_val = CNT_W'(clamp_ratio(32'(i_ratio)));

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_ratio_next  = r_ratio;
      w_clk_next    = r_clk;
      w_shadow_next = i_load ? w_load_val : r_shadow;
      w_wrap        = (r_cnt == (r_ratio - CNT_W'(1)));

      case (r_state)
         IDLE: begin
            // No period in flight, so a freshly loaded ratio takes effect at once.
            w_ratio_next = w_shadow_next;
            w_cnt_next   = '0;
            w_clk_next   = 1'b0;
            if (i_en) begin
               w_state_next = RUN;
               w_clk_next   = 1'b1;
            end
         end
         RUN, DRAIN: begin
            if (!i_en && w_wrap) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
               w_clk_next   = 1'b0;
               w_ratio_next = r_shadow;
            end else begin
               w_state_next = i_en ? RUN : DRAIN;
               // The shadow seen before this edge is what the next period uses;
               // a load on the wrap edge itself waits for the following wrap.
               if (w_wrap) begin
                  w_cnt_next   = '0;
                  w_ratio_next = r_shadow;
               end else begin
                  w_cnt_next   = r_cnt + CNT_W'(1);
               end
               w_clk_next = (w_cnt_next < (w_ratio_next >> 1));
            end
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_clk_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_shadow <= CNT_W'(MIN_RATIO);
         r_ratio  <= CNT_W'(MIN_RATIO);
         r_clk    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_shadow <= w_shadow_next;
         r_ratio  <= w_ratio_next;
         r_clk    <= w_clk_next;
      end
   end

`ifdef CLKDIV_TICK_EN
   logic r_tick;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_clk_next & ~r_clk;
      end
   end

   assign o_tick = r_tick;
`else
   assign o_tick = 1'b0;
`endif

   assign o_clk   = r_clk;
   assign o_state = r_state;

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel runtime-programmable clock divider: NUM_CH independent clkdiv_channel instances.
// Tick outputs are live only when CLKDIV_TICK_EN is defined; otherwise tied low.
module clock_divider_mc
   import clkdiv_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       div_en,
   input  logic [NUM_CH-1:0]       cfg_load,
   input  logic [NUM_CH*CNT_W-1:0] div_ratio,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       ch_active,
   output logic [NUM_CH-1:0]       tick
);

   state_e w_state [NUM_CH];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clkdiv_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .i_clk   (clk),
         .i_rst_n (reset),
         .i_en    (div_en[gi]),
         .i_load  (cfg_load[gi]),
         .i_ratio (div_ratio[gi*CNT_W +: CNT_W]),
         .o_clk   (clk_out[gi]),
         .o_tick  (tick[gi]),
         .o_state (w_state[gi])
      );

      assign ch_active[gi] = (w_state[gi] != IDLE);
   end

endmodule
